mat_cache: RTL and testbench

- Small register-file cache holding CACHE_SIZE square matrices, each WIDTH x WIDTH single-precision floats (shortreal).
- One vector write port and one vector read port, each WIDTH elements wide.
- Writes are synchronous and address a whole row or column. Reads are combinational and address a row, a column or a wrapped diagonal.
- Feeds the systolic matrix unit's data path: operands are loaded row/column-wise and read out diagonally for skewed streaming.

---
 rtl/mat_pkg.sv | 26 ++
 rtl/mat_cache_diag_index.sv | 20 ++
 rtl/mat_cache.sv | 112 +++++++++++
 tb/tb_mat_cache.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// mat_pkg: shared op encodings for the matrix register-file cache.
// Encodings are fixed; the diagonal write op exists even when not decoded.
package mat_pkg;

  typedef enum logic [1:0] {
    MAT_DATA_READ_NONE = 2'd0,
    MAT_DATA_READ_ROW  = 2'd1,
    MAT_DATA_READ_COL  = 2'd2,
    MAT_DATA_READ_DIAG = 2'd3
  } MatDataReadOp_t;

  typedef enum logic [1:0] {
    MAT_DATA_WRITE_NONE = 2'd0,
    MAT_DATA_WRITE_ROW  = 2'd1,
    MAT_DATA_WRITE_COL  = 2'd2,
    MAT_DATA_WRITE_DIAG = 2'd3
  } MatDataWriteOp_t;

  localparam shortreal MAT_ZERO = 0.0;

  // Index width that stays at least one bit for single-entry arrays.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mat_cache_diag_index.sv
// mat_cache_diag_index: wrapped anti-diagonal column index generator.
// col[i] = (param - i) mod WIDTH, relying on power-of-two wraparound.
module mat_cache_diag_index
  import mat_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IW = idx_w(WIDTH)
) (
  input  logic [IW-1:0] param,
  output logic [IW-1:0] col [WIDTH]
);

  // Truncating subtraction gives the modular wrap for free.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      col[i] = param - IW'(i);
    end
  end

endmodule

// File: rtl/mat_cache.sv
// mat_cache: CACHE_SIZE x WIDTH x WIDTH shortreal register-file cache.
// Optional diagonal write op enabled by MAT_CACHE_DIAG_WRITE_EN.
module mat_cache
  import mat_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int CACHE_SIZE = 4,
  localparam int IW = idx_w(WIDTH),
  localparam int AW = idx_w(CACHE_SIZE)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  MatDataReadOp_t  read_op,
  input  logic [AW-1:0]   read_addr1,
  input  logic [AW-1:0]   read_addr2,
  input  logic [IW-1:0]   read_param,
  input  MatDataWriteOp_t write_op,
  input  logic [AW-1:0]   write_addr1,
  input  logic [AW-1:0]   write_addr2,
  input  logic [IW-1:0]   write_param,
  input  shortreal        data_in  [WIDTH],
  output shortreal        data_out [WIDTH]
);

  shortreal mem [CACHE_SIZE][WIDTH][WIDTH];

  logic [IW-1:0] rd_col [WIDTH];

  // Secondary indices are reserved for future ops.
  logic unused_addr2;
  assign unused_addr2 = ^{read_addr2, write_addr2};

  mat_cache_diag_index #(
    .WIDTH (WIDTH)
  ) u_rd_diag (
    .param (read_param),
    .col   (rd_col)
  );

`ifdef MAT_CACHE_DIAG_WRITE_EN
  logic [IW-1:0] wr_col [WIDTH];

  mat_cache_diag_index #(
    .WIDTH (WIDTH)
  ) u_wr_diag (
    .param (write_param),
    .col   (wr_col)
  );
`endif

  // Storage update: reset clears everything and wins over writes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int c = 0; c < CACHE_SIZE; c++) begin
        for (int r = 0; r < WIDTH; r++) begin
          for (int k = 0; k < WIDTH; k++) begin
            mem[c][r][k] <= MAT_ZERO;
          end
        end
      end
    end else begin
      unique case (write_op)
        MAT_DATA_WRITE_ROW: begin
          for (int i = 0; i < WIDTH; i++) begin
            mem[write_addr1][write_param][i] <= data_in[i];
          end
        end
        MAT_DATA_WRITE_COL: begin
          for (int i = 0; i < WIDTH; i++) begin
            mem[write_addr1][i][write_param] <= data_in[i];
          end
        end
`ifdef MAT_CACHE_DIAG_WRITE_EN
        MAT_DATA_WRITE_DIAG: begin
          for (int i = 0; i < WIDTH; i++) begin
            mem[write_addr1][i][wr_col[i]] <= data_in[i];
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Zero-latency read mux; no bypass of same-cycle writes.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      data_out[i] = MAT_ZERO;
    end
    unique case (read_op)
      MAT_DATA_READ_ROW: begin
        for (int i = 0; i < WIDTH; i++) begin
          data_out[i] = mem[read_addr1][read_param][i];
        end
      end
      MAT_DATA_READ_COL: begin
        for (int i = 0; i < WIDTH; i++) begin
          data_out[i] = mem[read_addr1][i][read_param];
        end
      end
      MAT_DATA_READ_DIAG: begin
        for (int i = 0; i < WIDTH; i++) begin
          data_out[i] = mem[read_addr1][i][rd_col[i]];
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mat_cache.sv
// tb_mat_cache: directed checks of row/col/diag access and reset.
// Expected vectors are hand-computed constants.
module tb_mat_cache;
  import mat_pkg::*;

  localparam int WIDTH = 4;
  localparam int CACHE_SIZE = 4;

  logic            clock;
  logic            reset_n;
  MatDataReadOp_t  read_op;
  logic [1:0]      read_addr1;
  logic [1:0]      read_addr2;
  logic [1:0]      read_param;
  MatDataWriteOp_t write_op;
  logic [1:0]      write_addr1;
  logic [1:0]      write_addr2;
  logic [1:0]      write_param;
  shortreal        data_in  [WIDTH];
  shortreal        data_out [WIDTH];

  int n_run;
  int n_fail;

  mat_cache #(
    .WIDTH      (WIDTH),
    .CACHE_SIZE (CACHE_SIZE)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .read_op     (read_op),
    .read_addr1  (read_addr1),
    .read_addr2  (read_addr2),
    .read_param  (read_param),
    .write_op    (write_op),
    .write_addr1 (write_addr1),
    .write_addr2 (write_addr2),
    .write_param (write_param),
    .data_in     (data_in),
    .data_out    (data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input shortreal got,
                     input shortreal exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0.2f expected %0.2f", tag, got, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input shortreal e0,
                         input shortreal e1, input shortreal e2,
                         input shortreal e3);
    shortreal e [WIDTH];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < WIDTH; i++) begin
      chk($sformatf("%s[%0d]", tag, i), data_out[i], e[i]);
    end
  endtask

  task automatic set_vec(input shortreal v0, input shortreal v1,
                         input shortreal v2, input shortreal v3);
    data_in[0] = v0; data_in[1] = v1;
    data_in[2] = v2; data_in[3] = v3;
  endtask

  task automatic wr(input MatDataWriteOp_t op, input logic [1:0] a,
                    input logic [1:0] p, input shortreal v0,
                    input shortreal v1, input shortreal v2,
                    input shortreal v3);
    write_op = op;
    write_addr1 = a;
    write_param = p;
    set_vec(v0, v1, v2, v3);
    @(posedge clock);
    #1;
    write_op = MAT_DATA_WRITE_NONE;
  endtask

  task automatic rd(input MatDataReadOp_t op, input logic [1:0] a,
                    input logic [1:0] p);
    read_op = op;
    read_addr1 = a;
    read_param = p;
    #1;
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    reset_n = 1'b0;
    read_op = MAT_DATA_READ_NONE;
    read_addr1 = '0;
    read_addr2 = '0;
    read_param = '0;
    write_op = MAT_DATA_WRITE_NONE;
    write_addr1 = '0;
    write_addr2 = '0;
    write_param = '0;
    set_vec(0.0, 0.0, 0.0, 0.0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    rd(MAT_DATA_READ_ROW, 2'd0, 2'd0);
    chk_vec("reset_row0", 0.0, 0.0, 0.0, 0.0);

    wr(MAT_DATA_WRITE_ROW, 2'd0, 2'd0, 4.0, 6.0, 1.0, 6.0);
    rd(MAT_DATA_READ_ROW, 2'd0, 2'd0);
    chk_vec("row0_after_wr", 4.0, 6.0, 1.0, 6.0);
    wr(MAT_DATA_WRITE_ROW, 2'd0, 2'd1, 1.0, 2.0, 3.0, 4.0);
    wr(MAT_DATA_WRITE_ROW, 2'd0, 2'd2, 3.0, 3.0, 3.0, 3.0);
    wr(MAT_DATA_WRITE_ROW, 2'd0, 2'd3, 9.0, 7.0, 5.0, 3.0);

    rd(MAT_DATA_READ_DIAG, 2'd0, 2'd0);
    chk_vec("diag_p0", 4.0, 4.0, 3.0, 7.0);
    rd(MAT_DATA_READ_DIAG, 2'd0, 2'd1);
    chk_vec("diag_p1", 6.0, 1.0, 3.0, 5.0);
    rd(MAT_DATA_READ_DIAG, 2'd0, 2'd2);
    chk_vec("diag_p2", 1.0, 2.0, 3.0, 3.0);
    rd(MAT_DATA_READ_DIAG, 2'd0, 2'd3);
    chk_vec("diag_p3", 6.0, 3.0, 3.0, 9.0);
    rd(MAT_DATA_READ_COL, 2'd0, 2'd3);
    chk_vec("m0_col3", 6.0, 4.0, 3.0, 3.0);
    rd(MAT_DATA_READ_NONE, 2'd0, 2'd3);
    chk_vec("read_none", 0.0, 0.0, 0.0, 0.0);

    wr(MAT_DATA_WRITE_COL, 2'd2, 2'd1, 1.0, 2.0, 3.0, 4.0);
    wr(MAT_DATA_WRITE_COL, 2'd2, 2'd0, 3.0, 3.0, 3.0, 3.0);
    wr(MAT_DATA_WRITE_COL, 2'd2, 2'd3, 9.0, 7.0, 5.0, 3.0);
    wr(MAT_DATA_WRITE_COL, 2'd2, 2'd2, 9.0, 7.0, 5.0, 3.0);
    rd(MAT_DATA_READ_ROW, 2'd2, 2'd0);
    chk_vec("m2_row0", 3.0, 1.0, 9.0, 9.0);
    rd(MAT_DATA_READ_ROW, 2'd2, 2'd3);
    chk_vec("m2_row3", 3.0, 4.0, 3.0, 3.0);
    rd(MAT_DATA_READ_COL, 2'd2, 2'd1);
    chk_vec("m2_col1", 1.0, 2.0, 3.0, 4.0);
    rd(MAT_DATA_READ_ROW, 2'd0, 2'd3);
    chk_vec("m0_row3_kept", 9.0, 7.0, 5.0, 3.0);

    wr(MAT_DATA_WRITE_NONE, 2'd0, 2'd0, 1.0, 1.0, 1.0, 1.0);
    rd(MAT_DATA_READ_ROW, 2'd0, 2'd0);
    chk_vec("wr_none", 4.0, 6.0, 1.0, 6.0);

    rd(MAT_DATA_READ_ROW, 2'd1, 2'd0);
    write_op = MAT_DATA_WRITE_ROW;
    write_addr1 = 2'd1;
    write_param = 2'd0;
    set_vec(8.0, 8.0, 8.0, 8.0);
    #1;
    chk_vec("coll_before", 0.0, 0.0, 0.0, 0.0);
    @(posedge clock);
    #1;
    write_op = MAT_DATA_WRITE_NONE;
    chk_vec("coll_after", 8.0, 8.0, 8.0, 8.0);

    wr(MAT_DATA_WRITE_DIAG, 2'd3, 2'd1, 1.0, 2.0, 3.0, 4.0);
    rd(MAT_DATA_READ_DIAG, 2'd3, 2'd1);
`ifdef MAT_CACHE_DIAG_WRITE_EN
    chk_vec("diag_wr", 1.0, 2.0, 3.0, 4.0);
    rd(MAT_DATA_READ_ROW, 2'd3, 2'd1);
    chk_vec("diag_wr_row1", 2.0, 0.0, 0.0, 0.0);
`else
    chk_vec("diag_wr_off", 0.0, 0.0, 0.0, 0.0);
`endif

    reset_n = 1'b0;
    write_op = MAT_DATA_WRITE_ROW;
    write_addr1 = 2'd0;
    write_param = 2'd0;
    set_vec(5.0, 5.0, 5.0, 5.0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    write_op = MAT_DATA_WRITE_NONE;
    rd(MAT_DATA_READ_ROW, 2'd0, 2'd0);
    chk_vec("rst_prio", 0.0, 0.0, 0.0, 0.0);
    rd(MAT_DATA_READ_COL, 2'd2, 2'd1);
    chk_vec("rst_m2", 0.0, 0.0, 0.0, 0.0);
    rd(MAT_DATA_READ_ROW, 2'd1, 2'd0);
    chk_vec("rst_m1", 0.0, 0.0, 0.0, 0.0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
